// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared types and constants for board input conditioning
package board_io_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } dbnc_state_t;

    localparam int unsigned CLK_HZ              = 50000000;
    localparam int unsigned DEBOUNCE_MS_DEFAULT = 20;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized-width two-flop synchronizer, async active-high reset
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/switch_debounce_cntrl.sv
// rtl/switch_debounce_cntrl.sv - whole-vector debounce of switch/key inputs with commit strobe
module switch_debounce_cntrl
    import board_io_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS_DEFAULT
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] value,
    output logic             update,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    dbnc_state_t      state;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (CLOCK_50),
        .rst (reset),
        .d   (raw_in),
        .q   (sync)
    );

    // Any disagreement with the candidate restarts the window for every bit,
    // so a multi-bit change settling together commits as one update.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cand   <= '0;
            cnt    <= '0;
            value  <= '0;
            update <= 1'b0;
            rise   <= '0;
            fall   <= '0;
            busy   <= 1'b0;
        end else begin
            update <= 1'b0;
            rise   <= '0;
            fall   <= '0;
            case (state)
                IDLE: begin
                    if (sync != value) begin
                        cand  <= sync;
                        cnt   <= '0;
                        state <= SETTLE;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (sync != cand && sync == value) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sync != cand) begin
                        cand <= sync;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        value  <= cand;
                        update <= 1'b1;
                        rise   <= cand & ~value;
                        fall   <= ~cand & value;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce_cntrl.sv
// tb/tb_switch_debounce_cntrl.sv - self-checking bench for switch_debounce_cntrl
module tb_switch_debounce_cntrl;

    localparam int W = 3;
    localparam int D = 4;

    logic         CLOCK_50 = 1'b0;
    logic         reset    = 1'b0;
    logic [W-1:0] raw_in   = '0;
    logic [W-1:0] value;
    logic         update;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         busy;

    always #5 CLOCK_50 = ~CLOCK_50;

    switch_debounce_cntrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .raw_in   (raw_in),
        .value    (value),
        .update   (update),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the code seen by the debouncer lags raw_in by two edges;
    // value takes a code once D+1 consecutive samples agree on it.
    logic [W-1:0] raw_hist[$];
    logic [W-1:0] samp_hist[$];
    logic [W-1:0] m_value, m_rise, m_fall;
    logic         m_update, m_busy;

    function automatic void model_reset();
        raw_hist.delete();
        samp_hist.delete();
        raw_hist.push_back('0);
        raw_hist.push_back('0);
        for (int i = 0; i < D + 1; i++) samp_hist.push_back('0);
        m_value  = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_update = 1'b0;
        m_busy   = 1'b0;
    endfunction

    function automatic void model_edge(input logic [W-1:0] r);
        logic [W-1:0] s;
        bit stable;
        raw_hist.push_front(r);
        s = raw_hist[2];
        void'(raw_hist.pop_back());
        samp_hist.push_front(s);
        if (samp_hist.size() > D + 1) void'(samp_hist.pop_back());
        stable = 1'b1;
        foreach (samp_hist[i]) if (samp_hist[i] != s) stable = 1'b0;
        m_update = 1'b0;
        m_rise   = '0;
        m_fall   = '0;
        if (stable && s != m_value) begin
            m_rise   = s & ~m_value;
            m_fall   = ~s & m_value;
            m_value  = s;
            m_update = 1'b1;
        end
        m_busy = (s != m_value);
    endfunction

    task automatic check_out(input string name, input logic [W-1:0] ev, input logic eu,
                             input logic [W-1:0] er, input logic [W-1:0] ef, input logic eb);
        n_tests++;
        if ({value, update, rise, fall, busy} !== {ev, eu, er, ef, eb}) begin
            n_fail++;
            $display("FAIL %s @%0t: got value=%b update=%b rise=%b fall=%b busy=%b, expected value=%b update=%b rise=%b fall=%b busy=%b",
                     name, $time, value, update, rise, fall, busy, ev, eu, er, ef, eb);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input logic [W-1:0] r);
        raw_in = r;
        @(posedge CLOCK_50);
        model_edge(r);
        @(negedge CLOCK_50);
        check_out("model", m_value, m_update, m_rise, m_fall, m_busy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_out("reset_async", '0, 1'b0, '0, '0, 1'b0);
        model_reset();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] v;
        logic         u;
        logic [W-1:0] r;
        logic [W-1:0] f;
        logic         b;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [W-1:0] raw, input logic [W-1:0] v, input logic u,
                                input logic [W-1:0] r, input logic [W-1:0] f, input logic b);
        vec_t t;
        t.raw = raw; t.v = v; t.u = u; t.r = r; t.f = f; t.b = b;
        tbl.push_back(t);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int commit_edge;
        int n_upd;
        logic [W-1:0] c_rise, c_fall, c_value;
        int hold;
        logic [W-1:0] rnd;

        // quiet inputs: nothing moves
        for (int i = 0; i < 20; i++) add(3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
        // 000 -> 101: busy edges 3..6, commit on edge 7
        add(3'b101, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
        add(3'b101, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
        add(3'b101, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1);
        add(3'b101, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1);
        add(3'b101, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1);
        add(3'b101, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1);
        add(3'b101, 3'b101, 1'b1, 3'b101, 3'b000, 1'b0);
        add(3'b101, 3'b101, 1'b0, 3'b000, 3'b000, 1'b0);
        // bounce 101 -> 100 -> 101 aborts without commit
        add(3'b100, 3'b101, 1'b0, 3'b000, 3'b000, 1'b0);
        add(3'b100, 3'b101, 1'b0, 3'b000, 3'b000, 1'b0);
        add(3'b101, 3'b101, 1'b0, 3'b000, 3'b000, 1'b1);
        add(3'b101, 3'b101, 1'b0, 3'b000, 3'b000, 1'b1);
        add(3'b101, 3'b101, 1'b0, 3'b000, 3'b000, 1'b0);
        add(3'b101, 3'b101, 1'b0, 3'b000, 3'b000, 1'b0);

        #2;
        do_reset();
        foreach (tbl[i]) begin
            tick(tbl[i].raw);
            check_out("table", tbl[i].v, tbl[i].u, tbl[i].r, tbl[i].f, tbl[i].b);
        end

        // second change restarts the window: single commit of 011 on edge 9
        do_reset();
        commit_edge = -1; n_upd = 0; c_rise = '0; c_fall = '0;
        for (int i = 1; i <= 20; i++) begin
            tick(i <= 2 ? 3'b001 : 3'b011);
            if (update) begin
                n_upd++;
                if (commit_edge < 0) begin commit_edge = i; c_rise = rise; c_fall = fall; end
            end
        end
        check_int("restart_commit_edge", commit_edge, 9);
        check_int("restart_update_count", n_upd, 1);
        check_int("restart_rise", int'(c_rise), 3);
        check_int("restart_value", int'(value), 3);

        // change lands on the cnt==3 edge: restart wins, commit on edge 11
        commit_edge = -1; n_upd = 0; c_rise = '0; c_fall = '0;
        for (int i = 1; i <= 16; i++) begin
            tick(i <= 4 ? 3'b111 : 3'b110);
            if (i == 7) check_int("edge_race_no_commit", int'(update), 0);
            if (update) begin
                n_upd++;
                if (commit_edge < 0) begin commit_edge = i; c_rise = rise; c_fall = fall; end
            end
        end
        check_int("edge_race_commit_edge", commit_edge, 11);
        check_int("edge_race_update_count", n_upd, 1);
        check_int("edge_race_rise", int'(c_rise), 4);
        check_int("edge_race_fall", int'(c_fall), 1);

        // reset while settling, inputs held high through release
        for (int i = 1; i <= 4; i++) tick(3'b111);
        check_int("settle_busy_before_reset", int'(busy), 1);
        do_reset();
        commit_edge = -1; c_rise = '0; c_value = '0;
        for (int i = 1; i <= 12; i++) begin
            tick(3'b111);
            if (update && commit_edge < 0) begin commit_edge = i; c_rise = rise; c_value = value; end
        end
        check_int("post_reset_commit_edge", commit_edge, 7);
        check_int("post_reset_rise", int'(c_rise), 7);
        check_int("post_reset_value", int'(c_value), 7);

        // randomized held levels with occasional bounce and reset
        do_reset();
        hold = 0; rnd = '0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                rnd  = W'($urandom_range(0, 7));
                hold = $urandom_range(1, 9);
            end
            tick(rnd);
            hold--;
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
